// File: rtl/debounce_pkg.sv
// Shared state encodings and defaults for the input debouncer.
// Optional glitch counter is enabled with DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        PEND_LOW    = 2'b11
    } state_t;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned GLITCH_CNT_W        = 8;

endpackage

// File: rtl/sync_chain.sv
// Single-bit CDC synchroniser: STAGES flops in series, cleared by reset.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises din and accepts a new level after DEBOUNCE_CYCLES stable samples.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (s)
    );

    // busy is set alongside the state change so it mirrors the PEND states exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            glitch_cnt <= '0;
`endif
        end else begin
            case (state)
                STABLE_LOW: begin
                    if (en && s) begin
                        state <= PEND_HIGH;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                PEND_HIGH: begin
                    if (!en || !s) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                        if (en && glitch_cnt != '1)
                            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                        dout  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (en && !s) begin
                        state <= PEND_LOW;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                PEND_LOW: begin
                    if (!en || s) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                        if (en && glitch_cnt != '1)
                            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                        dout  <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

endmodule
